// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, memory-command and response bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int TAG_BITS = 4
);
  logic                d_req_valid;
  logic [1:0]          d_req_cmd;
  logic [31:0]         d_req_addr;
  logic [63:0]         d_req_data;
  logic                i_req_valid;
  logic [31:0]         i_req_addr;
  logic                d_req_accepted;
  logic                i_req_accepted;
  logic [TAG_BITS-1:0] d_req_tag;
  logic [TAG_BITS-1:0] i_req_tag;
  logic [1:0]          mem_cmd;
  logic [31:0]         mem_addr;
  logic [63:0]         mem_data_out;
  logic [TAG_BITS-1:0] mem_tag;
  logic [63:0]         mem_data_in;
  logic [TAG_BITS-1:0] mem_data_tag;
  logic                d_resp_valid;
  logic                i_resp_valid;
  logic [63:0]         resp_data;
  logic [TAG_BITS-1:0] resp_tag;
  logic                spurious_resp;

  modport slave (
    input  d_req_valid, d_req_cmd, d_req_addr, d_req_data,
    input  i_req_valid, i_req_addr,
    input  mem_tag, mem_data_in, mem_data_tag,
    output d_req_accepted, i_req_accepted, d_req_tag, i_req_tag,
    output mem_cmd, mem_addr, mem_data_out,
    output d_resp_valid, i_resp_valid, resp_data, resp_tag, spurious_resp
  );

  modport master (
    output d_req_valid, d_req_cmd, d_req_addr, d_req_data,
    output i_req_valid, i_req_addr,
    output mem_tag, mem_data_in, mem_data_tag,
    input  d_req_accepted, i_req_accepted, d_req_tag, i_req_tag,
    input  mem_cmd, mem_addr, mem_data_out,
    input  d_resp_valid, i_resp_valid, resp_data, resp_tag, spurious_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - D/I-cache arbiter for one memory command port with starvation
// guard and a per-tag owner table that routes returning load data.
module mem_arbiter #(
  parameter int TAG_BITS     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);
  localparam int NTAGS = 1 << TAG_BITS;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;

  logic [CW-1:0]       r_starve_cnt;
  logic [NTAGS-1:0]    r_busy;
  logic [NTAGS-1:0]    r_owner;
  logic                r_d_resp_valid;
  logic                r_i_resp_valid;
  logic                r_spurious;
  logic [63:0]         r_resp_data;
  logic [TAG_BITS-1:0] r_resp_tag;

  logic                w_d_valid;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_mem_ok;
  logic                w_i_acc;
  logic                w_alloc;
  logic                w_ret_nz;
  logic                w_ret_hit;
  logic [NTAGS-1:0]    w_busy_nxt;
  logic [NTAGS-1:0]    w_owner_nxt;

  assign w_d_valid = bus.d_req_valid && (bus.d_req_cmd != CMD_NONE);
  assign w_grant_d = w_d_valid && ((r_starve_cnt < LIMIT) || !bus.i_req_valid);
  assign w_grant_i = bus.i_req_valid && !w_grant_d;
  assign w_mem_ok  = (bus.mem_tag != '0);
  assign w_i_acc   = w_grant_i && w_mem_ok;

  assign bus.d_req_accepted = w_grant_d && w_mem_ok;
  assign bus.i_req_accepted = w_i_acc;
  assign bus.d_req_tag      = (w_grant_d && w_mem_ok) ? bus.mem_tag : '0;
  assign bus.i_req_tag      = w_i_acc ? bus.mem_tag : '0;

  assign bus.mem_cmd      = w_grant_d ? bus.d_req_cmd : (w_grant_i ? CMD_LOAD : CMD_NONE);
  assign bus.mem_addr     = w_grant_d ? bus.d_req_addr : (w_grant_i ? bus.i_req_addr : 32'd0);
  assign bus.mem_data_out = w_grant_d ? bus.d_req_data : 64'd0;

  // Only accepted loads own a tag; stores never come back with data.
  assign w_alloc   = w_mem_ok && (w_grant_i || (w_grant_d && bus.d_req_cmd == CMD_LOAD));
  assign w_ret_nz  = (bus.mem_data_tag != '0);
  assign w_ret_hit = w_ret_nz && r_busy[bus.mem_data_tag];

  // Retire before allocate so a same-cycle reuse of a tag leaves it busy for the new owner.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_owner_nxt = r_owner;
    if (w_ret_hit) begin
      w_busy_nxt[bus.mem_data_tag] = 1'b0;
    end
    if (w_alloc) begin
      w_busy_nxt[bus.mem_tag]  = 1'b1;
      w_owner_nxt[bus.mem_tag] = w_grant_i;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt   <= '0;
      r_busy         <= '0;
      r_owner        <= '0;
      r_d_resp_valid <= 1'b0;
      r_i_resp_valid <= 1'b0;
      r_spurious     <= 1'b0;
      r_resp_data    <= 64'd0;
      r_resp_tag     <= '0;
    end else begin
      if (!bus.i_req_valid || w_i_acc) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt < LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      r_busy         <= w_busy_nxt;
      r_owner        <= w_owner_nxt;
      r_d_resp_valid <= w_ret_hit && !r_owner[bus.mem_data_tag];
      r_i_resp_valid <= w_ret_hit && r_owner[bus.mem_data_tag];
      r_spurious     <= w_ret_nz && !r_busy[bus.mem_data_tag];
      if (w_ret_hit) begin
        r_resp_data <= bus.mem_data_in;
        r_resp_tag  <= bus.mem_data_tag;
      end
    end
  end

  assign bus.d_resp_valid  = r_d_resp_valid;
  assign bus.i_resp_valid  = r_i_resp_valid;
  assign bus.spurious_resp = r_spurious;
  assign bus.resp_data     = r_resp_data;
  assign bus.resp_tag      = r_resp_tag;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  localparam int TB  = 4;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.TAG_BITS(TB)) bus();
  mem_arbiter #(.TAG_BITS(TB), .STARVE_LIMIT(LIM)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  int   m_starve;
  bit   m_busy[16];
  bit   m_own[16];

  typedef struct {
    logic       dv;
    logic [1:0] dcmd;
    logic       iv;
    logic [3:0] mtag;
    logic       e_dacc;
    logic [3:0] e_dtag;
    logic       e_iacc;
    logic [3:0] e_itag;
    logic [1:0] e_cmd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.d_req_valid = 1'b0; bus.d_req_cmd = 2'd0; bus.d_req_addr = 32'd0; bus.d_req_data = 64'd0;
    bus.i_req_valid = 1'b0; bus.i_req_addr = 32'd0;
    bus.mem_tag = '0; bus.mem_data_in = 64'd0; bus.mem_data_tag = '0;
  endtask

  task automatic model_clear();
    m_starve = 0;
    for (int t = 0; t < 16; t++) begin m_busy[t] = 1'b0; m_own[t] = 1'b0; end
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_d_resp", 64'(bus.d_resp_valid), 64'd0);
    chk("rst_i_resp", 64'(bus.i_resp_valid), 64'd0);
    chk("rst_spurious", 64'(bus.spurious_resp), 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: compare combinational outputs against the grant rules, advance the model, compare registered outputs.
  task automatic step();
    bit dv, gd, gi, acc, e_d, e_i, e_s;
    int t;
    logic [1:0] e_cmd;
    #1;
    dv  = bus.d_req_valid && bus.d_req_cmd != 2'd0;
    gd  = 1'b0; gi = 1'b0;
    if (dv && m_starve < LIM) gd = 1'b1;
    else if (bus.i_req_valid) gi = 1'b1;
    else if (dv) gd = 1'b1;
    acc = (bus.mem_tag != 0);
    e_cmd = gd ? bus.d_req_cmd : (gi ? 2'd1 : 2'd0);
    chk("d_acc", 64'(bus.d_req_accepted), 64'(gd && acc));
    chk("i_acc", 64'(bus.i_req_accepted), 64'(gi && acc));
    chk("d_tag", 64'(bus.d_req_tag), (gd && acc) ? 64'(bus.mem_tag) : 64'd0);
    chk("i_tag", 64'(bus.i_req_tag), (gi && acc) ? 64'(bus.mem_tag) : 64'd0);
    chk("mem_cmd", 64'(bus.mem_cmd), 64'(e_cmd));
    chk("mem_addr", 64'(bus.mem_addr), gd ? 64'(bus.d_req_addr) : (gi ? 64'(bus.i_req_addr) : 64'd0));
    chk("mem_data_out", bus.mem_data_out, gd ? bus.d_req_data : 64'd0);
    t = int'(bus.mem_data_tag);
    e_d = 1'b0; e_i = 1'b0; e_s = 1'b0;
    if (t != 0) begin
      if (m_busy[t]) begin
        if (m_own[t]) e_i = 1'b1; else e_d = 1'b1;
        m_busy[t] = 1'b0;
      end else e_s = 1'b1;
    end
    if (acc && (gi || (gd && bus.d_req_cmd == 2'd1))) begin
      m_busy[int'(bus.mem_tag)] = 1'b1;
      m_own[int'(bus.mem_tag)]  = gi;
    end
    if (bus.i_req_valid && !(gi && acc)) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    else m_starve = 0;
    begin
      logic [63:0] e_data = bus.mem_data_in;
      @(posedge clk); #1;
      chk("d_resp", 64'(bus.d_resp_valid), 64'(e_d));
      chk("i_resp", 64'(bus.i_resp_valid), 64'(e_i));
      chk("spurious", 64'(bus.spurious_resp), 64'(e_s));
      if (e_d || e_i) begin
        chk("resp_data", bus.resp_data, e_data);
        chk("resp_tag", 64'(bus.resp_tag), 64'(t));
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 2'd1, 1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 4'd0, 2'd1};
    vecs[1] = '{1'b1, 2'd2, 1'b0, 4'd2,  1'b1, 4'd2,  1'b0, 4'd0, 2'd2};
    vecs[2] = '{1'b1, 2'd0, 1'b1, 4'd5,  1'b0, 4'd0,  1'b1, 4'd5, 2'd1};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0, 2'd1};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 4'd4,  1'b0, 4'd0,  1'b0, 4'd0, 2'd0};
    vecs[5] = '{1'b1, 2'd1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0, 2'd1};
    vecs[6] = '{1'b1, 2'd2, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 4'd0, 2'd2};
    vecs[7] = '{1'b1, 2'd0, 1'b0, 4'd1,  1'b0, 4'd0,  1'b0, 4'd0, 2'd0};

    do_reset();
    for (int v = 0; v < 8; v++) begin
      do_reset();
      bus.d_req_valid = vecs[v].dv; bus.d_req_cmd = vecs[v].dcmd;
      bus.d_req_addr = 32'h1000_0000 + 32'(v); bus.i_req_valid = vecs[v].iv;
      bus.i_req_addr = 32'h2000_0000 + 32'(v); bus.mem_tag = vecs[v].mtag;
      #1;
      chk("tbl_d_acc", 64'(bus.d_req_accepted), 64'(vecs[v].e_dacc));
      chk("tbl_d_tag", 64'(bus.d_req_tag), 64'(vecs[v].e_dtag));
      chk("tbl_i_acc", 64'(bus.i_req_accepted), 64'(vecs[v].e_iacc));
      chk("tbl_i_tag", 64'(bus.i_req_tag), 64'(vecs[v].e_itag));
      chk("tbl_mem_cmd", 64'(bus.mem_cmd), 64'(vecs[v].e_cmd));
    end

    // Starvation rotation: D wins four cycles, I wins the fifth.
    do_reset();
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.i_req_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      bus.mem_tag = 4'((k % 15) + 1);
      #1;
      chk("starve_i_win", 64'(bus.i_req_accepted), 64'(k % 5 == 4));
      step();
    end

    // I-cache load tag 5, data returns ten cycles later.
    do_reset();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0ABC; bus.mem_tag = 4'd5;
    step();
    set_idle();
    for (int k = 0; k < 10; k++) step();
    bus.mem_data_tag = 4'd5; bus.mem_data_in = 64'hDEADBEEF_CAFEF00D;
    step();
    chk("s3_i_resp", 64'(bus.i_resp_valid), 64'd1);
    chk("s3_d_resp", 64'(bus.d_resp_valid), 64'd0);
    chk("s3_data", bus.resp_data, 64'hDEADBEEF_CAFEF00D);
    chk("s3_tag", 64'(bus.resp_tag), 64'd5);
    step();
    chk("s3_freed", 64'(bus.spurious_resp), 64'd1);

    // Store allocates nothing; rejected request allocates nothing; tag 0 never retires.
    do_reset();
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd2; bus.mem_tag = 4'd2; bus.d_req_data = 64'h1234;
    step();
    set_idle();
    bus.mem_data_tag = 4'd2;
    step();
    chk("s4_spurious", 64'(bus.spurious_resp), 64'd1);
    chk("s4_no_resp", 64'(bus.d_resp_valid), 64'd0);
    set_idle();
    bus.i_req_valid = 1'b1; bus.mem_tag = 4'd0;
    step();
    set_idle();
    step();
    chk("s4_tag0_quiet", 64'(bus.spurious_resp), 64'd0);

    // Same-cycle retire and reallocate of tag 7.
    do_reset();
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.mem_tag = 4'd7;
    step();
    set_idle();
    bus.i_req_valid = 1'b1; bus.mem_tag = 4'd7; bus.mem_data_tag = 4'd7; bus.mem_data_in = 64'hAAAA;
    step();
    chk("s5_d_resp", 64'(bus.d_resp_valid), 64'd1);
    chk("s5_i_resp", 64'(bus.i_resp_valid), 64'd0);
    set_idle();
    bus.mem_data_tag = 4'd7; bus.mem_data_in = 64'hBBBB;
    step();
    chk("s5_i_resp2", 64'(bus.i_resp_valid), 64'd1);
    chk("s5_data2", bus.resp_data, 64'hBBBB);

    // Reset while tag 9 is outstanding and a response is being presented.
    do_reset();
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.mem_tag = 4'd9;
    step();
    bus.mem_tag = 4'd10;
    step();
    set_idle();
    bus.mem_data_tag = 4'd10; bus.mem_data_in = 64'h55;
    step();
    set_idle();
    rst = 1'b1;
    #1;
    chk("s6_async_d_resp", 64'(bus.d_resp_valid), 64'd0);
    chk("s6_async_data", bus.resp_data, 64'd0);
    chk("s6_async_tag", 64'(bus.resp_tag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    bus.mem_data_tag = 4'd9; bus.mem_data_in = 64'h99;
    step();
    chk("s6_spurious", 64'(bus.spurious_resp), 64'd1);
    chk("s6_no_d_resp", 64'(bus.d_resp_valid), 64'd0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      bus.d_req_valid  = 1'($urandom_range(0, 1));
      bus.d_req_cmd    = 2'($urandom_range(0, 2));
      bus.d_req_addr   = $urandom;
      bus.d_req_data   = {$urandom, $urandom};
      bus.i_req_valid  = 1'($urandom_range(0, 1));
      bus.i_req_addr   = $urandom;
      bus.mem_tag      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.mem_data_tag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.mem_data_in  = {$urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter between the D-cache subsystem, the I-cache and the single-ported memory model. Each cycle it grants the memory command port to at most one requester, tracking priority and starvation. It returns the memory's transaction tag and accept status to the winner. It records which requester owns each outstanding load tag, so that tagged memory data is routed back as a registered, per-requester response pulse.

## Interface
- TAG_BITS, 4: width of memory transaction tag; tag 0 means "not accepted / no data".
- STARVE_LIMIT, 4: consecutive cycles the I-cache may be denied while requesting before it takes priority.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- d_req_valid / d_req_cmd / d_req_addr / d_req_data  in  1 / 2 / 32 / 64  D-cache request: valid, command (1=LOAD, 2=STORE, 0=NONE), block address, store data.
- i_req_valid / i_req_addr  in  1 / 32  I-cache request; always a LOAD.
- d_req_accepted, i_req_accepted  out  1  request taken by memory this cycle.
- d_req_tag, i_req_tag  out  TAG_BITS  tag assigned to an accepted request; 0 otherwise.
- mem_cmd / mem_addr / mem_data_out  out  2 / 32 / 64  command to memory; NONE when idle.
- mem_tag  in  TAG_BITS  tag returned by memory for this cycle's command; 0 means rejected.
- mem_data_in / mem_data_tag  in  64 / TAG_BITS  returning load data and its tag; tag 0 means no data.
- d_resp_valid, i_resp_valid  out  1  registered response pulse for the owning requester.
- resp_data / resp_tag  out  64 / TAG_BITS  registered data and tag for the response.
- spurious_resp  out  1  registered pulse: nonzero mem_data_tag with no owner recorded.

## Operation
- Grant rule, evaluated combinationally:
  - D-cache wins if d_req_valid and starve_cnt < STARVE_LIMIT.
  - Otherwise I-cache wins if i_req_valid.
  - Otherwise D-cache wins if d_req_valid.
- A D-cache request with d_req_cmd==NONE is treated as not valid.
- The granted requester drives mem_cmd, mem_addr and mem_data_out. mem_data_out is 0 for I-cache. With no grant, mem_cmd=NONE, mem_addr=0, mem_data_out=0.
- Accept: x_req_accepted = granted_x && mem_tag != 0. x_req_tag = mem_tag when accepted, else 0. The loser sees accepted=0, tag=0.
- starve_cnt (saturating):
  - Increments when i_req_valid is high and I-cache is not accepted.
  - Clears to 0 when I-cache is accepted or i_req_valid is low.
  - Saturates at STARVE_LIMIT.
- Owner table, one entry per tag 1..2^TAG_BITS-1, each {busy, owner}, owner 0=D, 1=I:
  - An accepted LOAD sets entry[mem_tag] = {1, requester}.
  - An accepted STORE allocates nothing and never produces a response.
- Response path:
  - When mem_data_tag != 0 and entry[mem_data_tag].busy, the next cycle pulses d_resp_valid or i_resp_valid according to owner, with resp_data=mem_data_in and resp_tag=mem_data_tag. The entry is cleared.
  - A nonzero tag on a non-busy entry pulses spurious_resp the next cycle, with no resp_valid and no table change.
- Same tag retired and reallocated in one cycle: the clear is applied first, then the set. The entry ends busy with the new owner, and the response goes to the old owner.
- Tag 0 never allocates or retires.

## Timing
- Request to accept: 0 cycles (combinational through mem_tag).
- Memory data to response: 1 cycle (registered).
- Reset values:
  - All resp_valid, spurious_resp = 0; resp_data = 0; resp_tag = 0.
  - starve_cnt = 0; all table entries not busy.
  - Combinational outputs follow their inputs.
- Reset asserted mid-transaction:
  - Table is cleared.
  - Data that arrives after reset for pre-reset tags raises spurious_resp only, and is not forwarded.
- One grant per cycle max; both resp_valid are never high together.

## Test plan
- Both request a LOAD; mem_tag=3; starve_cnt=0 -> d_req_accepted=1 with d_req_tag=3; i_req_accepted=0 with i_req_tag=0; starve_cnt becomes 1.
- I-cache and D-cache request continuously with mem_tag nonzero, STARVE_LIMIT=4 -> D-cache wins cycles 0-3, I-cache wins cycle 4 and starve_cnt returns to 0, pattern repeats.
- I-cache LOAD accepted with tag 5; 10 cycles later mem_data_tag=5 and mem_data_in=0xDEADBEEF_CAFEF00D -> next cycle i_resp_valid=1, resp_tag=5, resp_data matches, d_resp_valid=0; entry 5 is freed.
- D-cache STORE accepted with tag 2; later mem_data_tag=2 -> spurious_resp=1, no resp_valid. Also: mem_tag=0 on a request -> accepted=0, nothing allocated.
- D-cache LOAD tag 7 outstanding; the same cycle brings mem_data_tag=7 and a new I-cache LOAD with mem_tag=7 -> D-cache gets the response; entry 7 is now owned by I-cache; a later tag-7 data goes to I-cache.
- D-cache LOAD tag 9 outstanding; assert reset for 1 cycle; then mem_data_tag=9 -> spurious_resp=1, d_resp_valid=0; all outputs held at reset values during reset.
